interrupt_sequencer: RTL

// - Upstream of the CAR latch control. Generates its rst and INTREQ inputs and supplies the vector address.
// - Stretches and releases power-on/pin reset.
// - Edge-detects the NMI and arbitrates maskable IRQs under GIE.
// - Holds one request until the microsequencer's IF point, then freezes the winner until the vector-load step acks it.

---
 rtl/interrupt_sequencer_pkg.sv | 18 +
 rtl/interrupt_sequencer_sync_edge_detect.sv | 28 ++
 rtl/interrupt_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings and default vectors for the interrupt sequencer.
// Vectors are fetched by the CAR latch control's interrupt entry microcode.
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_PEND     = 3'd3,
    ST_SERVICE  = 3'd4
  } state_e;

  // VEC_RST is consumed by CAR_INT0 (reset entry); VEC_NMI/VEC_BASE by CAR_INT4 (vector load).
  localparam logic [15:0] VEC_RST  = 16'hFFFE;
  localparam logic [15:0] VEC_NMI  = 16'hFFFC;
  localparam logic [15:0] VEC_BASE = 16'hFFFA;

endpackage

// File: rtl/interrupt_sequencer_sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser followed by a rising-edge pulse.
// The pulse is high for one cycle, two to three clocks after the pin rises.
module interrupt_sequencer_sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset stretcher, NMI edge capture and maskable IRQ arbitration feeding the CAR latch control.
// One request is held until IF, then frozen until the vector-load step acks it.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned N_IRQ      = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter logic [15:0] VEC_RST    = interrupt_sequencer_pkg::VEC_RST,
  parameter logic [15:0] VEC_NMI    = interrupt_sequencer_pkg::VEC_NMI,
  parameter logic [15:0] VEC_BASE   = interrupt_sequencer_pkg::VEC_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nmi_in,
  input  logic [N_IRQ-1:0] irq,
  input  logic             gie,
  input  logic             IF,
  input  logic             int_ack,
  output logic             rst,
  output logic             INTREQ,
  output logic [15:0]      int_vec,
  output logic [N_IRQ-1:0] irq_ack
);

  localparam int unsigned SW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  function automatic logic [SW:0] arbitrate(input logic [N_IRQ-1:0] req);
    logic [SW:0] r;
    r = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) r = {1'b1, SW'(i)};
    end
    return r;
  endfunction

  function automatic logic [15:0] vec_of(input logic is_nmi, input logic [SW-1:0] src);
    return is_nmi ? VEC_NMI : (VEC_BASE - (16'(src) << 1));
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            rst_q;
  logic            intreq_q;
  logic [15:0]     int_vec_q;
  logic [N_IRQ-1:0] irq_ack_q;
  logic            sel_nmi_q;
  logic [SW-1:0]   sel_src_q;
  logic            nmi_pend_q;
  logic            nmi_pend_d;

  logic            nmi_rise;
  logic            mask_vld;
  logic [SW-1:0]   mask_src;
  logic            win_vld;
  logic            win_nmi;
  logic            nmi_clr;

  interrupt_sequencer_sync_edge_detect u_nmi_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (nmi_in),
    .rise_o  (nmi_rise)
  );

  always_comb begin
    {mask_vld, mask_src} = arbitrate(irq & {N_IRQ{gie}});
    win_nmi = nmi_pend_q;
    win_vld = nmi_pend_q | mask_vld;
    nmi_clr = (state_q == ST_SERVICE) && int_ack && sel_nmi_q;
    // A fresh edge in the ack cycle keeps the pending flag set.
    nmi_pend_d = nmi_rise | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      cnt_q      <= CW'(RST_CYCLES - 1);
      rst_q      <= 1'b1;
      intreq_q   <= 1'b0;
      int_vec_q  <= VEC_RST;
      irq_ack_q  <= '0;
      sel_nmi_q  <= 1'b0;
      sel_src_q  <= '0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_pend_q <= nmi_pend_d;
      irq_ack_q  <= '0;
      case (state_q)
        ST_RESET: begin
          if (cnt_q == '0) begin
            state_q <= ST_RST_WAIT;
            rst_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RST_WAIT: begin
          int_vec_q <= VEC_RST;
          if (int_ack) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (win_vld) begin
            state_q   <= ST_PEND;
            intreq_q  <= 1'b1;
            sel_nmi_q <= win_nmi;
            sel_src_q <= mask_src;
          end
        end
        ST_PEND: begin
          if (IF) begin
            // Fetch point wins over a same-cycle cancel: the last held winner is serviced.
            state_q  <= ST_SERVICE;
            intreq_q <= 1'b0;
            if (win_vld) begin
              sel_nmi_q <= win_nmi;
              sel_src_q <= mask_src;
              int_vec_q <= vec_of(win_nmi, mask_src);
            end else begin
              int_vec_q <= vec_of(sel_nmi_q, sel_src_q);
            end
          end else if (!win_vld) begin
            state_q  <= ST_IDLE;
            intreq_q <= 1'b0;
          end else begin
            sel_nmi_q <= win_nmi;
            sel_src_q <= mask_src;
          end
        end
        ST_SERVICE: begin
          if (int_ack) begin
            state_q <= ST_IDLE;
            if (!sel_nmi_q) irq_ack_q <= {{(N_IRQ-1){1'b0}}, 1'b1} << sel_src_q;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          intreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst     = rst_q;
  assign INTREQ  = intreq_q;
  assign int_vec = int_vec_q;
  assign irq_ack = irq_ack_q;

endmodule
